// File: rtl/controller_pkt_serializer.sv
// controller_pkt_serializer: two-slot ping-pong buffer replaying wide packets as a word stream
module controller_pkt_serializer #(
    parameter int DBITS = 32,
    parameter int LBITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [DBITS*(2**LBITS)-1:0]   pkt_in,
    input  logic [LBITS-1:0]              pkt_len,
    input  logic                          pkt_valid,
    output logic                          pkt_ready,
    output logic [DBITS-1:0]              dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          dout_last,
    output logic                          empty,
    output logic                          full
);
    localparam int PKT = 2**LBITS;
    typedef logic [PKT-1:0][DBITS-1:0] pkt_t;

    pkt_t             data_q [2];
    pkt_t             data_d [2];
    logic [LBITS:0]   len_q  [2];
    logic [LBITS:0]   len_d  [2];
    logic [1:0]       vld_q, vld_d;
    logic             wr_q, wr_d, rd_q, rd_d;
    logic [LBITS-1:0] idx_q, idx_d;
    logic             accept, xfer;

    assign full       = vld_q[0] & vld_q[1];
    assign empty      = ~vld_q[0] & ~vld_q[1];
    assign pkt_ready  = ~full;
    assign dout_valid = vld_q[rd_q];
    assign dout       = dout_valid ? data_q[rd_q][idx_q] : '0;
    assign dout_last  = dout_valid && ({1'b0, idx_q} == len_q[rd_q] - 1'b1);
    assign accept     = pkt_valid & pkt_ready;
    assign xfer       = dout_valid & dout_ready;

    // Next state: flush wins; otherwise load into the write slot and drain the read slot independently
    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        vld_d  = vld_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        idx_d  = idx_q;
        if (flush) begin
            data_d[0] = '0;
            data_d[1] = '0;
            vld_d     = '0;
            wr_d      = 1'b0;
            rd_d      = 1'b0;
            idx_d     = '0;
        end else begin
            if (accept) begin
                data_d[wr_q] = pkt_in;
                len_d[wr_q]  = (pkt_len == '0) ? (LBITS+1)'(PKT) : {1'b0, pkt_len};
                vld_d[wr_q]  = 1'b1;
                wr_d         = ~wr_q;
            end
            if (xfer && dout_last) begin
                vld_d[rd_q]  = 1'b0;
                data_d[rd_q] = '0;
                idx_d        = '0;
                rd_d         = ~rd_q;
            end else if (xfer) begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            len_q[0]  <= '0;
            len_q[1]  <= '0;
            vld_q     <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            idx_q     <= '0;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
            vld_q  <= vld_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            idx_q  <= idx_d;
        end
    end
endmodule

// File: tb/tb_controller_pkt_serializer.sv
// tb_controller_pkt_serializer: directed scenarios plus randomized traffic against a word-queue model
module tb_controller_pkt_serializer;
    localparam int DBITS = 32;
    localparam int LBITS = 4;
    localparam int PKT   = 16;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   flush = 1'b0;
    logic [DBITS*PKT-1:0]   pkt_in = '0;
    logic [LBITS-1:0]       pkt_len = '0;
    logic                   pkt_valid = 1'b0;
    logic                   pkt_ready;
    logic [DBITS-1:0]       dout;
    logic                   dout_valid;
    logic                   dout_ready = 1'b0;
    logic                   dout_last;
    logic                   empty;
    logic                   full;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    controller_pkt_serializer #(.DBITS(DBITS), .LBITS(LBITS)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .pkt_in(pkt_in), .pkt_len(pkt_len), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
        .empty(empty), .full(full)
    );

    wire [4:0] flags = {dout_valid, dout_last, pkt_ready, empty, full};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int j = 0; j < PKT; j++) pkt_in[32*j +: 32] = base + 32'(j);
    endtask

    task automatic test_reset;
        #3;
        tests++;
        if (flags !== 5'b00110 || dout !== 32'h0) begin
            fails++;
            $display("FAIL reset_async: flags=%b dout=%h expected flags=00110 dout=0", flags, dout);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        tests++;
        if (flags !== 5'b00110 || dout !== 32'h0) begin
            fails++;
            $display("FAIL reset_release: flags=%b dout=%h expected flags=00110 dout=0", flags, dout);
        end
    endtask

    task automatic test_full_packet;
        logic [31:0] exp;
        fill(32'h1000_0000);
        pkt_len = 4'd0;
        pkt_valid = 1'b1;
        dout_ready = 1'b1;
        tick();
        pkt_valid = 1'b0;
        for (int j = 0; j < PKT; j++) begin
            exp = 32'h1000_0000 + 32'(j);
            tests++;
            if (dout !== exp || dout_valid !== 1'b1 || dout_last !== (j == PKT-1)) begin
                fails++;
                $display("FAIL full_pkt word %0d: dout=%h v=%b last=%b expected %h v=1 last=%b",
                         j, dout, dout_valid, dout_last, exp, (j == PKT-1));
            end
            tick();
        end
        tests++;
        if (flags !== 5'b00110 || dout !== 32'h0) begin
            fails++;
            $display("FAIL full_pkt_after: flags=%b dout=%h expected flags=00110 dout=0", flags, dout);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ew [5];
        logic [4:0]  ef [6];
        ew = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hB000_0000, 32'hB000_0001};
        ef = '{5'b10100, 5'b10001, 5'b11001, 5'b10100, 5'b11100, 5'b00110};
        fill(32'hA000_0000);
        pkt_len = 4'd3;
        pkt_valid = 1'b1;
        dout_ready = 1'b1;
        tick();
        fill(32'hB000_0000);
        pkt_len = 4'd2;
        for (int c = 0; c < 6; c++) begin
            tests++;
            if (flags !== ef[c] || dout !== (c < 5 ? ew[c] : 32'h0)) begin
                fails++;
                $display("FAIL b2b cycle %0d: flags=%b dout=%h expected flags=%b dout=%h",
                         c, flags, dout, ef[c], (c < 5 ? ew[c] : 32'h0));
            end
            tick();
            pkt_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        int k = 0;
        fill(32'hC000_0000);
        pkt_len = 4'd4;
        pkt_valid = 1'b1;
        dout_ready = 1'b0;
        tick();
        pkt_valid = 1'b0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            dout_ready = (c % 3 == 0);
            tests++;
            if (dout !== 32'hC000_0000 + 32'(k) || dout_valid !== 1'b1 || dout_last !== (k == 3)) begin
                fails++;
                $display("FAIL backpressure cycle %0d: dout=%h v=%b last=%b expected %h v=1 last=%b",
                         c, dout, dout_valid, dout_last, 32'hC000_0000 + 32'(k), (k == 3));
            end
            tick();
            if (dout_ready) k++;
        end
        dout_ready = 1'b1;
        tests++;
        if (flags !== 5'b00110) begin
            fails++;
            $display("FAIL backpressure_end: flags=%b expected 00110", flags);
        end
    endtask

    task automatic test_simultaneous;
        fill(32'hD000_0000);
        pkt_len = 4'd2;
        pkt_valid = 1'b1;
        dout_ready = 1'b0;
        tick();
        pkt_valid = 1'b0;
        dout_ready = 1'b1;
        tick();
        tests++;
        if (dout !== 32'hD000_0001 || flags !== 5'b11100) begin
            fails++;
            $display("FAIL simul_pre: dout=%h flags=%b expected d0000001 flags=11100", dout, flags);
        end
        pkt_in = '0;
        pkt_in[31:0] = 32'hDEAD_BEEF;
        pkt_len = 4'd1;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        tests++;
        if (dout !== 32'hDEAD_BEEF || flags !== 5'b11100) begin
            fails++;
            $display("FAIL simul_new: dout=%h flags=%b expected deadbeef flags=11100", dout, flags);
        end
        tick();
        tests++;
        if (flags !== 5'b00110) begin
            fails++;
            $display("FAIL simul_end: flags=%b expected 00110", flags);
        end
    endtask

    task automatic test_flush;
        dout_ready = 1'b0;
        fill(32'hE000_0000);
        pkt_len = 4'd3;
        pkt_valid = 1'b1;
        tick();
        fill(32'hF000_0000);
        tick();
        tests++;
        if (flags !== 5'b10001 || dout !== 32'hE000_0000) begin
            fails++;
            $display("FAIL flush_full: flags=%b dout=%h expected flags=10001 dout=e0000000", flags, dout);
        end
        fill(32'h5555_0000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pkt_valid = 1'b0;
        tests++;
        if (flags !== 5'b00110 || dout !== 32'h0) begin
            fails++;
            $display("FAIL flush_after: flags=%b dout=%h expected flags=00110 dout=0", flags, dout);
        end
        dout_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            tests++;
            if (dout_valid !== 1'b0) begin
                fails++;
                $display("FAIL flush_drop cycle %0d: dout_valid=%b dout=%h expected valid=0", c, dout_valid, dout);
            end
        end
    endtask

    task automatic test_async_reset;
        fill(32'h7000_0000);
        pkt_len = 4'd0;
        pkt_valid = 1'b1;
        dout_ready = 1'b1;
        tick();
        pkt_valid = 1'b0;
        repeat (5) tick();
        tests++;
        if (dout !== 32'h7000_0005) begin
            fails++;
            $display("FAIL areset_pre: dout=%h expected 70000005", dout);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (flags !== 5'b00110 || dout !== 32'h0) begin
            fails++;
            $display("FAIL areset_now: flags=%b dout=%h expected flags=00110 dout=0", flags, dout);
        end
        @(negedge clk);
        reset = 1'b0;
        fill(32'h8000_0000);
        pkt_len = 4'd2;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tests++;
            if (j < 2 ? (dout !== 32'h8000_0000 + 32'(j) || flags !== {1'b1, j == 1, 3'b100})
                      : (flags !== 5'b00110)) begin
                fails++;
                $display("FAIL areset_next word %0d: dout=%h flags=%b", j, dout, flags);
            end
            tick();
        end
    endtask

    task automatic test_random;
        logic [31:0] wq [$];
        bit          lq [$];
        int          npk = 0;
        int          L;
        logic [31:0] w;
        for (int c = 0; c < 800; c++) begin
            for (int j = 0; j < PKT; j++) pkt_in[32*j +: 32] = $urandom;
            pkt_len    = 4'($urandom);
            pkt_valid  = ($urandom_range(0, 2) != 0);
            dout_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 59) == 0);
            w = (npk > 0) ? wq[0] : 32'h0;
            tests++;
            if (dout_valid !== (npk > 0) || dout !== w || dout_last !== (npk > 0 && lq[0])
                || pkt_ready !== (npk < 2) || empty !== (npk == 0) || full !== (npk == 2)) begin
                fails++;
                $display("FAIL random cycle %0d: dout=%h v=%b last=%b rdy=%b e=%b f=%b expected dout=%h v=%b last=%b pkts=%0d",
                         c, dout, dout_valid, dout_last, pkt_ready, empty, full,
                         w, (npk > 0), (npk > 0 && lq[0]), npk);
            end
            if (flush) begin
                wq.delete();
                lq.delete();
                npk = 0;
            end else begin
                if (npk > 0 && dout_ready) begin
                    if (lq[0]) npk--;
                    void'(wq.pop_front());
                    void'(lq.pop_front());
                end
                if (pkt_valid && pkt_ready) begin
                    L = (pkt_len == 0) ? PKT : int'(pkt_len);
                    for (int j = 0; j < L; j++) begin
                        wq.push_back(pkt_in[32*j +: 32]);
                        lq.push_back(j == L-1);
                    end
                    npk++;
                end
            end
            tick();
        end
        flush = 1'b0;
        pkt_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_back_to_back();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
